// File: rtl/clk_en_sequencer.sv
// PPU/CPU clock-resource controller: lock-gated reset sequencing, divide-by-CPU_DIV
// CPU enable with M2 level, and debugger pause / single-step of the CPU enable.
module clk_en_sequencer #(
  parameter int CPU_DIV          = 3,
  parameter int LOCK_SYNC_STAGES = 2,
  parameter int PPU_RST_CYCLES   = 16,
  parameter int CPU_RST_CYCLES   = 8
) (
  input  logic       clk_ppu,
  input  logic       rst_ppu_n,
  input  logic       locked,
  input  logic       pause_req,
  input  logic       step_req,
  output logic       rst_ppu,
  output logic       rst_cpu,
  output logic       cpu_en,
  output logic [1:0] cpu_phase,
  output logic       m2,
  output logic       paused,
  output logic [2:0] seq_state
);

  localparam int CNT_MAX = (PPU_RST_CYCLES > CPU_RST_CYCLES) ? PPU_RST_CYCLES : CPU_RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0]       PH_LAST  = 2'(CPU_DIV - 1);
  localparam logic [CNT_W-1:0] PPU_LAST = CNT_W'(PPU_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CPU_LAST = CNT_W'(CPU_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_PPU_RST   = 3'd1,
    S_CPU_RST   = 3'd2,
    S_RUN       = 3'd3,
    S_PAUSED    = 3'd4,
    S_STEP      = 3'd5
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [LOCK_SYNC_STAGES-1:0] r_lock_sync;
  logic [1:0]                  r_phase;
  logic [1:0]                  w_phase_nxt;
  logic [1:0]                  w_phase_inc;
  logic [CNT_W-1:0]            r_cnt;
  logic [CNT_W-1:0]            w_cnt_nxt;
  logic                        w_locked_s;
  logic                        w_counting;
  logic                        w_cpu_en;

  assign w_locked_s  = r_lock_sync[LOCK_SYNC_STAGES-1];
  assign w_phase_inc = (r_phase == PH_LAST) ? '0 : r_phase + 2'd1;
  assign w_counting  = (r_state == S_CPU_RST) || (r_state == S_RUN) || (r_state == S_STEP);
  assign w_cpu_en    = w_counting && (r_phase == PH_LAST);

  always_ff @(posedge clk_ppu or negedge rst_ppu_n) begin
    if (!rst_ppu_n) begin
      r_lock_sync <= '0;
      r_state     <= S_WAIT_LOCK;
      r_phase     <= '0;
      r_cnt       <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[LOCK_SYNC_STAGES-2:0], locked};
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = '0;
    w_cnt_nxt   = '0;
    case (r_state)
      S_WAIT_LOCK: begin
        if (w_locked_s) w_state_nxt = S_PPU_RST;
      end
      S_PPU_RST: begin
        if (r_cnt == PPU_LAST) w_state_nxt = S_CPU_RST;
        else                   w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      S_CPU_RST: begin
        w_phase_nxt = w_phase_inc;
        w_cnt_nxt   = r_cnt;
        if (w_cpu_en) begin
          if (r_cnt == CPU_LAST) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
      end
      S_RUN: begin
        w_phase_nxt = w_phase_inc;
        if (w_cpu_en && pause_req) w_state_nxt = S_PAUSED;
      end
      S_PAUSED: begin
        if (!pause_req)    w_state_nxt = S_RUN;
        else if (step_req) w_state_nxt = S_STEP;
      end
      S_STEP: begin
        w_phase_nxt = w_phase_inc;
        if (w_cpu_en) w_state_nxt = pause_req ? S_PAUSED : S_RUN;
      end
      default: w_state_nxt = S_WAIT_LOCK;
    endcase
    // Lock loss overrides every transition above and clears all counters.
    if ((r_state != S_WAIT_LOCK) && !w_locked_s) begin
      w_state_nxt = S_WAIT_LOCK;
      w_phase_nxt = '0;
      w_cnt_nxt   = '0;
    end
  end

  always_comb begin
    rst_ppu   = !((r_state == S_CPU_RST) || (r_state == S_RUN) ||
                  (r_state == S_PAUSED)  || (r_state == S_STEP));
    rst_cpu   = !((r_state == S_RUN) || (r_state == S_PAUSED) || (r_state == S_STEP));
    cpu_en    = w_cpu_en;
    cpu_phase = r_phase;
    m2        = w_counting && (r_phase != 2'd0);
    paused    = (r_state == S_PAUSED);
    seq_state = r_state;
  end

endmodule

// File: tb/tb_clk_en_sequencer.sv
// Bench for clk_en_sequencer: three instances (CPU_DIV 3, 2, 4) on shared inputs,
// each compared every cycle against a time-since-lock reference model.
module tb_clk_en_sequencer;

  localparam int NI  = 3;
  localparam int LSS = 2;
  localparam int PPU = 16;
  localparam int CRC = 8;
  localparam logic [9:0] RST_VEC = 10'b11_0_00_0_0_000;

  logic clk = 1'b0;
  logic rst_n, locked, pause_req, step_req;

  logic       o_rst_ppu [NI];
  logic       o_rst_cpu [NI];
  logic       o_cpu_en  [NI];
  logic [1:0] o_phase   [NI];
  logic       o_m2      [NI];
  logic       o_paused  [NI];
  logic [2:0] o_state   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    clk_en_sequencer #(
      .CPU_DIV          ((g == 0) ? 3 : (g == 1) ? 2 : 4),
      .LOCK_SYNC_STAGES (LSS),
      .PPU_RST_CYCLES   (PPU),
      .CPU_RST_CYCLES   (CRC)
    ) u_dut (
      .clk_ppu   (clk),
      .rst_ppu_n (rst_n),
      .locked    (locked),
      .pause_req (pause_req),
      .step_req  (step_req),
      .rst_ppu   (o_rst_ppu[g]),
      .rst_cpu   (o_rst_cpu[g]),
      .cpu_en    (o_cpu_en[g]),
      .cpu_phase (o_phase[g]),
      .m2        (o_m2[g]),
      .paused    (o_paused[g]),
      .seq_state (o_state[g])
    );
  end

  // Reference model: "up" = sequence started, m_t = clocks since leaving WAIT_LOCK.
  bit m_sync [NI][LSS];
  bit m_up [NI], m_hold [NI], m_stepping [NI];
  int m_t [NI], m_ph [NI];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int en_cnt0 = 0;

  function automatic int div_of(input int i);
    return (i == 0) ? 3 : (i == 1) ? 2 : 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < LSS; k++) m_sync[i][k] = 1'b0;
      m_up[i] = 0; m_hold[i] = 0; m_stepping[i] = 0; m_t[i] = 0; m_ph[i] = 0;
    end
  endtask

  task automatic model_edge(input int i);
    bit cur, en;
    int d, tend;
    d = div_of(i);
    tend = PPU + CRC * d;
    if (!rst_n) begin
      for (int k = 0; k < LSS; k++) m_sync[i][k] = 1'b0;
      m_up[i] = 0; m_hold[i] = 0; m_stepping[i] = 0; m_t[i] = 0; m_ph[i] = 0;
      return;
    end
    cur = m_sync[i][LSS-1];
    for (int k = LSS - 1; k > 0; k--) m_sync[i][k] = m_sync[i][k-1];
    m_sync[i][0] = locked;
    if (!m_up[i]) begin
      if (cur) begin m_up[i] = 1; m_t[i] = 0; end
    end else if (!cur) begin
      m_up[i] = 0; m_t[i] = 0; m_ph[i] = 0; m_hold[i] = 0; m_stepping[i] = 0;
    end else if (m_t[i] < tend) begin
      if (m_t[i] >= PPU) m_ph[i] = (m_ph[i] + 1) % d;
      m_t[i]++;
    end else if (m_hold[i]) begin
      if (!pause_req) m_hold[i] = 0;
      else if (step_req) begin m_hold[i] = 0; m_stepping[i] = 1; end
    end else begin
      en = (m_ph[i] == d - 1);
      m_ph[i] = (m_ph[i] + 1) % d;
      if (en) begin m_stepping[i] = 0; m_hold[i] = pause_req; end
    end
  endtask

  function automatic logic [9:0] exp_vec(input int i);
    int d, tend;
    bit cnt_st;
    logic [2:0] st;
    d = div_of(i);
    tend = PPU + CRC * d;
    cnt_st = m_up[i] && (m_t[i] >= PPU) && !m_hold[i];
    if (!m_up[i])           st = 3'd0;
    else if (m_t[i] < PPU)  st = 3'd1;
    else if (m_t[i] < tend) st = 3'd2;
    else if (m_hold[i])     st = 3'd4;
    else if (m_stepping[i]) st = 3'd5;
    else                    st = 3'd3;
    return {!m_up[i] || (m_t[i] < PPU), !m_up[i] || (m_t[i] < tend),
            cnt_st && (m_ph[i] == d - 1), 2'(m_ph[i]), cnt_st && (m_ph[i] != 0),
            m_hold[i], st};
  endfunction

  function automatic logic [9:0] obs_vec(input int i);
    return {o_rst_ppu[i], o_rst_cpu[i], o_cpu_en[i], o_phase[i], o_m2[i], o_paused[i], o_state[i]};
  endfunction

  task automatic check_vec(input string tag, input int i, input logic [9:0] expv);
    logic [9:0] obs;
    obs = obs_vec(i);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s div=%0d cyc=%0d observed=%b expected=%b", tag, div_of(i), cyc, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_edge(i);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) check_vec("outputs", i, exp_vec(i));
    en_cnt0 += int'(o_cpu_en[0]);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int drop;
    int w;
    rst_n = 1'b0; locked = 1'b0; pause_req = 1'b0; step_req = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < NI; i++) check_vec("reset_async", i, RST_VEC);
    ticks(3);

    // Power-up and full reset sequence into RUN.
    rst_n = 1'b1; locked = 1'b1;
    ticks(80);

    // Pause raised at phase 0 of the DIV=3 instance, then released.
    w = 0;
    while (m_ph[0] != 0 && w < 10) begin tick(); w++; end
    pause_req = 1'b1;
    ticks(10);
    pause_req = 1'b0;
    ticks(8);

    // Single stepping: three isolated steps, then a step with a second pulse mid-STEP.
    pause_req = 1'b1;
    ticks(12);
    en_cnt0 = 0;
    for (int s = 0; s < 3; s++) begin
      step_req = 1'b1; tick(); step_req = 1'b0;
      ticks(9);
    end
    check_int("step_x3_cpu_en", en_cnt0, 3);
    en_cnt0 = 0;
    step_req = 1'b1; tick(); step_req = 1'b0; tick();
    step_req = 1'b1; tick(); step_req = 1'b0;
    ticks(8);
    check_int("step_dropped_cpu_en", en_cnt0, 1);
    pause_req = 1'b0;
    ticks(6);

    // Lock loss during RUN, then relock and full sequence.
    locked = 1'b0; ticks(5);
    locked = 1'b1; ticks(25);
    // Lock loss mid CPU_RST, then relock.
    locked = 1'b0; ticks(5);
    locked = 1'b1; ticks(80);

    // Randomised traffic: pause level, step pulses, occasional lock glitches.
    drop = 0;
    for (int r = 0; r < 900; r++) begin
      if ($urandom_range(0, 15) == 0) pause_req = ~pause_req;
      step_req = ($urandom_range(0, 5) == 0);
      if (drop > 0) begin
        drop--;
        locked = (drop == 0);
      end else if ($urandom_range(0, 249) == 0) begin
        drop = int'($urandom_range(1, 4));
        locked = 1'b0;
      end
      tick();
    end
    step_req = 1'b0; locked = 1'b1; pause_req = 1'b0;
    ticks(80);

    // Asynchronous reset mid-STEP, off the clock edge.
    pause_req = 1'b1;
    ticks(12);
    step_req = 1'b1; tick(); step_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < NI; i++) check_vec("reset_mid_step", i, RST_VEC);
    ticks(3);
    @(negedge clk);
    rst_n = 1'b1; pause_req = 1'b0;
    ticks(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
